// File: rtl/dm_pkg.sv
// DMI payload types shared by the debug module and its DTM-side infrastructure.
package dm;

  localparam int unsigned DmiAddrW = 7;
  localparam int unsigned DmiDataW = 32;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [DmiAddrW-1:0] addr;
    dtm_op_e             op;
    logic [DmiDataW-1:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [DmiDataW-1:0] data;
    logic [1:0]          resp;
  } dmi_resp_t;

endpackage

// File: rtl/dm_dmi_rr_sel.sv
// Round-robin picker: first valid requester at or after ptr_i, wrapping modulo NrPorts.
module dm_dmi_rr_sel #(
  parameter int unsigned NrPorts = 2,
  localparam int unsigned IdxW = $clog2(NrPorts)
) (
  input  logic [NrPorts-1:0] valid_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [NrPorts-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o,
  output logic               any_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NrPorts);
      if (!any_o && valid_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dm_dmi_arbiter.sv
// Shares one DM DMI port among several DTM requesters, one transaction in flight at a time.
module dm_dmi_arbiter #(
  parameter int unsigned NrPorts = 2,
  localparam int unsigned IdxW = $clog2(NrPorts)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic      [NrPorts-1:0]       req_valid_i,
  output logic      [NrPorts-1:0]       req_ready_o,
  input  dm::dmi_req_t [NrPorts-1:0]    req_i,
  output logic      [NrPorts-1:0]       resp_valid_o,
  input  logic      [NrPorts-1:0]       resp_ready_i,
  output dm::dmi_resp_t [NrPorts-1:0]   resp_o,
  output logic                          dmi_req_valid_o,
  input  logic                          dmi_req_ready_i,
  output dm::dmi_req_t                  dmi_req_o,
  input  logic                          dmi_resp_valid_i,
  output logic                          dmi_resp_ready_o,
  input  dm::dmi_resp_t                 dmi_resp_i,
  output logic      [IdxW-1:0]          owner_o
);

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  dm::dmi_req_t    req_q, req_d;

  logic [NrPorts-1:0] gnt;
  logic [IdxW-1:0]    win_idx;
  logic               any_valid;

  dm_dmi_rr_sel #(
    .NrPorts(NrPorts)
  ) u_rr_sel (
    .valid_i(req_valid_i),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (win_idx),
    .any_o  (any_valid)
  );

  assign dmi_req_o = req_q;
  assign owner_o   = owner_q;
  assign resp_o    = {NrPorts{dmi_resp_i}};

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    req_d            = req_q;
    req_ready_o      = '0;
    resp_valid_o     = '0;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;

    case (state_q)
      StIdle: begin
        // Grant is combinational, so keep it quiet while reset is held.
        if (any_valid && rst_ni) begin
          req_ready_o = gnt;
          req_d       = req_i[win_idx];
          owner_d     = win_idx;
          state_d     = StFwd;
        end
      end
      StFwd: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        resp_valid_o[owner_q] = dmi_resp_valid_i;
        dmi_resp_ready_o      = resp_ready_i[owner_q];
        if (dmi_resp_valid_i && resp_ready_i[owner_q]) begin
          state_d  = StIdle;
          rr_ptr_d = (32'(owner_q) == NrPorts - 1) ? '0 : owner_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      req_q    <= req_d;
    end
  end

endmodule

// File: tb/tb_dm_dmi_arbiter.sv
// Scoreboard bench for dm_dmi_arbiter with two requesters and a scripted DM model.
module tb_dm_dmi_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req_valid, req_ready, resp_valid, resp_ready;
  dm::dmi_req_t  [1:0] req;
  dm::dmi_resp_t [1:0] resp;
  logic dmi_req_valid, dmi_req_ready, dmi_resp_valid, dmi_resp_ready;
  dm::dmi_req_t  dmi_req;
  dm::dmi_resp_t dmi_resp;
  logic owner;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          port;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic [1:0]  gnt;
    logic        owner;
    logic [6:0]  addr;
    logic [31:0] data;
    bit          lat_ok;
    bit          stable;
    bit          rstall_ok;
    bit          hs_ok;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    int          waited;
    bit          timeout;
  } obs_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  dm_dmi_arbiter #(.NrPorts(2)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_i           (req),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_o          (resp),
    .dmi_req_valid_o (dmi_req_valid),
    .dmi_req_ready_i (dmi_req_ready),
    .dmi_req_o       (dmi_req),
    .dmi_resp_valid_i(dmi_resp_valid),
    .dmi_resp_ready_o(dmi_resp_ready),
    .dmi_resp_i      (dmi_resp),
    .owner_o         (owner)
  );

  // Drives one transaction through the DM side and records what the DUT showed; no judging here.
  task automatic txn(input int req_stall, input int resp_stall, input logic [31:0] rdata,
                     input bit hold, output obs_t o);
    dm::dmi_req_t held;
    int idx;
    o = '{default: 0};
    #1;
    while (!(|req_ready) && o.waited < 20) begin
      @(negedge clk); #1;
      o.waited++;
    end
    if (!(|req_ready)) begin
      o.timeout = 1;
      return;
    end
    o.gnt = req_ready;
    idx   = req_ready[1] ? 1 : 0;
    @(negedge clk);
    if (!hold) req_valid[idx] = 1'b0;
    dmi_req_ready = (req_stall == 0);
    #1;
    o.lat_ok = dmi_req_valid;
    o.addr   = dmi_req.addr;
    o.data   = dmi_req.data;
    o.owner  = owner;
    held     = dmi_req;
    o.stable = 1;
    for (int c = 0; c < req_stall; c++) begin
      @(negedge clk);
      dmi_resp_valid = 1'b1;
      dmi_req_ready  = (c == req_stall - 1);
      #1;
      if (!dmi_req_valid || dmi_req !== held || req_ready !== 2'b00 ||
          dmi_resp_ready !== 1'b0 || resp_valid !== 2'b00) o.stable = 0;
    end
    @(negedge clk);
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b1;
    dmi_resp       = '{data: rdata, resp: 2'b00};
    o.rstall_ok    = 1;
    for (int c = 0; c < resp_stall; c++) begin
      resp_ready = ~o.gnt;
      #1;
      if (dmi_resp_ready !== 1'b0 || req_ready !== 2'b00 || resp_valid !== o.gnt) o.rstall_ok = 0;
      @(negedge clk);
    end
    resp_ready = 2'b11;
    #1;
    o.resp_valid = resp_valid;
    o.resp_data  = resp[idx].data;
    o.hs_ok      = dmi_resp_ready;
    @(negedge clk);
    dmi_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    req = '0;
    resp_ready = 2'b11;
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b1;
    dmi_resp = '0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
    tests++; if (dmi_req_valid !== 1'b0) begin fails++; $display("FAIL reset_dmi_req_valid: got %b want 0", dmi_req_valid); end
    tests++; if (dmi_resp_ready !== 1'b0) begin fails++; $display("FAIL reset_dmi_resp_ready: got %b want 0", dmi_resp_ready); end
    tests++; if (owner !== 1'b0) begin fails++; $display("FAIL reset_owner: got %b want 0", owner); end
    tests++; if (dmi_req !== '0) begin fails++; $display("FAIL reset_dmi_req: got %h want 0", dmi_req); end
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 2'b00;
    dmi_resp_valid = 1'b0;
  endtask

  task automatic test_single();
    obs_t o;
    exp_t e;
    @(negedge clk);
    req[0] = '{addr: 7'h11, op: dm::DTM_READ, data: 32'h0};
    req_valid = 2'b01;
    exp_q.push_back('{0, 7'h11, 32'h0, 32'hDEADBEEF});
    txn(0, 0, exp_q[0].rdata, 0, o);
    e = exp_q.pop_front();
    tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL single_gnt: got %b want %b", o.gnt, 2'(1 << e.port)); end
    tests++; if (o.lat_ok !== 1'b1) begin fails++; $display("FAIL single_latency: dmi_req_valid %b want 1", o.lat_ok); end
    tests++; if (o.addr !== e.addr) begin fails++; $display("FAIL single_addr: got %h want %h", o.addr, e.addr); end
    tests++; if (o.resp_valid !== 2'(1 << e.port)) begin fails++; $display("FAIL single_resp_valid: got %b want %b", o.resp_valid, 2'(1 << e.port)); end
    tests++; if (o.resp_data !== e.rdata) begin fails++; $display("FAIL single_resp_data: got %h want %h", o.resp_data, e.rdata); end
    tests++; if (o.hs_ok !== 1'b1) begin fails++; $display("FAIL single_dmi_resp_ready: got %b want 1", o.hs_ok); end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req[0] = '{addr: 7'h20, op: dm::DTM_WRITE, data: 32'hA0A0_0000};
    req[1] = '{addr: 7'h21, op: dm::DTM_WRITE, data: 32'hA1A1_0001};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{k % 2, (k % 2 == 0) ? 7'h20 : 7'h21, (k % 2 == 0) ? 32'hA0A0_0000 : 32'hA1A1_0001,
                        32'h5000_0000 + 32'(k)});
    for (int k = 0; k < 4; k++) begin
      txn(0, 0, exp_q[0].rdata, 1, o);
      e = exp_q.pop_front();
      tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL simul_gnt[%0d]: got %b want %b", k, o.gnt, 2'(1 << e.port)); end
      tests++; if (o.owner !== e.port[0]) begin fails++; $display("FAIL simul_owner[%0d]: got %b want %0d", k, o.owner, e.port); end
      tests++; if (o.data !== e.data) begin fails++; $display("FAIL simul_data[%0d]: got %h want %h", k, o.data, e.data); end
      tests++; if (o.resp_data !== e.rdata) begin fails++; $display("FAIL simul_resp_data[%0d]: got %h want %h", k, o.resp_data, e.rdata); end
      tests++; if (o.waited !== 0) begin fails++; $display("FAIL simul_spacing[%0d]: idle wait %0d want 0", k, o.waited); end
    end
    req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    obs_t o;
    exp_t e;
    req[0] = '{addr: 7'h05, op: dm::DTM_WRITE, data: 32'h1234_5678};
    req[1] = '{addr: 7'h06, op: dm::DTM_READ, data: 32'h0};
    req_valid = 2'b11;
    exp_q.push_back('{0, 7'h05, 32'h1234_5678, 32'hC0FF_EE00});
    txn(5, 0, exp_q[0].rdata, 1, o);
    req_valid = 2'b00;
    e = exp_q.pop_front();
    tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL bp_gnt: got %b want %b", o.gnt, 2'(1 << e.port)); end
    tests++; if (o.stable !== 1'b1) begin fails++; $display("FAIL bp_stable: request or ready moved during stall (%b)", o.stable); end
    tests++; if (o.data !== e.data) begin fails++; $display("FAIL bp_data: got %h want %h", o.data, e.data); end
    tests++; if (o.resp_valid !== 2'(1 << e.port)) begin fails++; $display("FAIL bp_resp_valid: got %b want %b", o.resp_valid, 2'(1 << e.port)); end
  endtask

  task automatic test_resp_stall();
    obs_t o;
    exp_t e;
    req[0] = '{addr: 7'h0A, op: dm::DTM_READ, data: 32'h0};
    req[1] = '{addr: 7'h0B, op: dm::DTM_READ, data: 32'h0};
    req_valid = 2'b11;
    exp_q.push_back('{1, 7'h0B, 32'h0, 32'h1111_2222});
    exp_q.push_back('{0, 7'h0A, 32'h0, 32'h3333_4444});
    txn(0, 4, exp_q[0].rdata, 1, o);
    e = exp_q.pop_front();
    tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL rstall_gnt: got %b want %b", o.gnt, 2'(1 << e.port)); end
    tests++; if (o.rstall_ok !== 1'b1) begin fails++; $display("FAIL rstall_hold: WAIT not held during stall (%b)", o.rstall_ok); end
    tests++; if (o.resp_valid !== 2'(1 << e.port)) begin fails++; $display("FAIL rstall_resp_valid: got %b want %b", o.resp_valid, 2'(1 << e.port)); end
    tests++; if (o.resp_data !== e.rdata) begin fails++; $display("FAIL rstall_resp_data: got %h want %h", o.resp_data, e.rdata); end
    txn(0, 0, exp_q[0].rdata, 1, o);
    req_valid = 2'b00;
    e = exp_q.pop_front();
    tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL rstall_next_gnt: got %b want %b", o.gnt, 2'(1 << e.port)); end
  endtask

  task automatic test_reset_in_wait();
    obs_t o;
    exp_t e;
    req[1] = '{addr: 7'h3F, op: dm::DTM_READ, data: 32'h0};
    req_valid = 2'b10;
    #1;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL rwait_accept: got %b want 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    dmi_req_ready = 1'b1;
    @(negedge clk);
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b1;
    dmi_resp = '{data: 32'h0BAD_0BAD, resp: 2'b00};
    resp_ready = 2'b11;
    #1;
    tests++; if (resp_valid !== 2'b10) begin fails++; $display("FAIL rwait_in_wait: got %b want 10", resp_valid); end
    rst_n = 1'b0;
    #1;
    tests++; if (resp_valid !== 2'b00) begin fails++; $display("FAIL rwait_resp_valid: got %b want 00", resp_valid); end
    tests++; if (dmi_resp_ready !== 1'b0) begin fails++; $display("FAIL rwait_dmi_resp_ready: got %b want 0", dmi_resp_ready); end
    tests++; if (owner !== 1'b0) begin fails++; $display("FAIL rwait_owner: got %b want 0", owner); end
    tests++; if (dmi_req !== '0 || dmi_req_valid !== 1'b0) begin fails++; $display("FAIL rwait_dmi_req: got %h/%b want 0/0", dmi_req, dmi_req_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    dmi_resp_valid = 1'b0;
    req[0] = '{addr: 7'h01, op: dm::DTM_READ, data: 32'h0};
    req_valid = 2'b11;
    exp_q.push_back('{0, 7'h01, 32'h0, 32'h0000_0001});
    exp_q.push_back('{1, 7'h3F, 32'h0, 32'h0000_0002});
    txn(0, 0, exp_q[0].rdata, 0, o);
    e = exp_q.pop_front();
    tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL rwait_first_gnt: got %b want %b", o.gnt, 2'(1 << e.port)); end
    req_valid = 2'b10;
    txn(0, 0, exp_q[0].rdata, 0, o);
    e = exp_q.pop_front();
    tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL rwait_port1_gnt: got %b want %b", o.gnt, 2'(1 << e.port)); end
    tests++; if (o.addr !== e.addr) begin fails++; $display("FAIL rwait_port1_addr: got %h want %h", o.addr, e.addr); end
  endtask

  task automatic test_stray();
    obs_t o;
    exp_t e;
    req_valid = 2'b00;
    dmi_resp_valid = 1'b1;
    dmi_resp = '{data: 32'hFFFF_0000, resp: 2'b00};
    for (int c = 0; c < 3; c++) begin
      #1;
      tests++; if (dmi_resp_ready !== 1'b0 || resp_valid !== 2'b00) begin fails++; $display("FAIL stray[%0d]: dmi_resp_ready %b resp_valid %b want 0/00", c, dmi_resp_ready, resp_valid); end
      @(negedge clk);
    end
    dmi_resp_valid = 1'b0;
    req[0] = '{addr: 7'h44, op: dm::DTM_READ, data: 32'h0};
    req_valid = 2'b01;
    exp_q.push_back('{0, 7'h44, 32'h0, 32'h7777_8888});
    txn(0, 0, exp_q[0].rdata, 0, o);
    e = exp_q.pop_front();
    tests++; if (o.gnt !== 2'(1 << e.port)) begin fails++; $display("FAIL stray_next_gnt: got %b want %b", o.gnt, 2'(1 << e.port)); end
    tests++; if (o.resp_data !== e.rdata || o.resp_valid !== 2'(1 << e.port)) begin fails++; $display("FAIL stray_next_resp: got %h/%b want %h/%b", o.resp_data, o.resp_valid, e.rdata, 2'(1 << e.port)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_resp_stall();
    test_reset_in_wait();
    test_stray();
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dm_dmi_arbiter.md
DM_DMI_ARBITER -- requirements
Module: dm_dmi_arbiter

Interface
REQ-001 SHALL have parameter NrPorts, default 2, number of DTM requesters sharing one DM DMI port (legal 2..8).
REQ-002 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i  input  NrPorts  per-requester DMI request valid.
REQ-005 SHALL have port req_ready_o  output  NrPorts  per-requester request accept.
REQ-006 SHALL have port req_i  input  NrPorts x dm::dmi_req_t  per-requester request (addr, op, data).
REQ-007 SHALL have port resp_valid_o  output  NrPorts  per-requester response valid.
REQ-008 SHALL have port resp_ready_i  input  NrPorts  per-requester response accept.
REQ-009 SHALL have port resp_o  output  NrPorts x dm::dmi_resp_t  response, broadcast to all; qualified only by resp_valid_o.
REQ-010 SHALL have port dmi_req_valid_o  output  1  request valid toward DM.
REQ-011 SHALL have port dmi_req_ready_i  input  1  DM request accept.
REQ-012 SHALL have port dmi_req_o  output  dm::dmi_req_t  request toward DM.
REQ-013 SHALL have port dmi_resp_valid_i  input  1  DM response valid.
REQ-014 SHALL have port dmi_resp_ready_o  output  1  response accept toward DM.
REQ-015 SHALL have port dmi_resp_i  input  dm::dmi_resp_t  DM response.
REQ-016 SHALL have port owner_o  output  $clog2(NrPorts)  index of current/last granted requester (debug visibility).

Function
REQ-017 SHALL implement FSM IDLE -> FWD -> WAIT -> IDLE; exactly one DMI transaction outstanding at any time.
REQ-018 IDLE: if any req_valid_i set, SHALL pick winner round-robin starting at rr_ptr, assert req_ready_o only for winner in same cycle, register req_i[winner] and winner index, go FWD.
REQ-019 IDLE with no valid: all req_ready_o = 0, FSM stays IDLE, rr_ptr unchanged.
REQ-020 FWD: dmi_req_valid_o = 1 with registered request; on dmi_req_ready_i = 1 go WAIT; request held stable while stalled.
REQ-021 WAIT: resp_valid_o[owner] = dmi_resp_valid_i, dmi_resp_ready_o = resp_ready_i[owner], resp_o = dmi_resp_i (combinational pass-through); on handshake go IDLE, rr_ptr <= owner+1 modulo NrPorts.
REQ-022 Non-owner resp_valid_o SHALL be 0 in all states; all req_ready_o SHALL be 0 outside IDLE.
REQ-023 dmi_resp_valid_i outside WAIT SHALL be ignored (dmi_resp_ready_o = 0).
REQ-024 Latency: requester accept cycle N -> dmi_req_valid_o cycle N+1; minimum accept-to-accept spacing 3 cycles.
REQ-025 Requester dropping req_valid_i without handshake SHALL have no effect; arbitration re-evaluated each IDLE cycle.
REQ-026 Fairness: with all ports continuously requesting, each port SHALL be granted once per NrPorts transactions.

Reset
REQ-027 On rst_ni = 0: FSM IDLE, rr_ptr 0, owner_o 0, registered request 0; req_ready_o, resp_valid_o, dmi_req_valid_o, dmi_resp_ready_o all 0.
REQ-028 Reset mid-transaction SHALL abandon it without emitting a response; first grant after reset goes to lowest-index valid port.

Structure
REQ-029 SHALL reuse dm::dmi_req_t and dm::dmi_resp_t from the dm package; no new package typedefs; FSM state enum local.
REQ-030 Round-robin selection SHALL be one combinational sub-module dm_dmi_rr_sel (inputs valid vector, rr_ptr; outputs one-hot grant, index, any).

Verification
REQ-031 Single: port0 read addr 0x11 -> dmi_req_o.addr=0x11 cycle+1; DM resp data 0xDEADBEEF -> only resp_valid_o[0] with 0xDEADBEEF.
REQ-032 Simultaneous: ports 0,1 valid from reset, always ready -> grant order 0,1,0,1; owner_o tracks.
REQ-033 Backpressure: dmi_req_ready_i low 5 cycles -> dmi_req_o stable, req_ready_o all 0 until response completes.
REQ-034 Response stall: resp_ready_i[1]=0 for 4 cycles -> dmi_resp_ready_o=0, FSM held in WAIT, port0 not granted.
REQ-035 Reset in WAIT: rst_ni low 1 cycle -> all outputs 0, no resp_valid_o; next request from port1 alone granted.
REQ-036 Stray: dmi_resp_valid_i=1 in IDLE -> dmi_resp_ready_o=0, no resp_valid_o.
